// File: rtl/muller_c_proj_formal_chk_if.sv
// Pad-side bus of the muller_c_proj checker: raw io_in/io_out/io_oeb plus
// the coverage counter and the exported hold-property flag.
interface muller_c_proj_formal_chk_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       io_in;
  logic [5:0]       io_out;
  logic [5:0]       io_oeb;
  logic [CNT_W-1:0] rise_cnt;
  logic             hold_viol;

  modport master (
    output io_in,
    input  io_out,
    input  io_oeb,
    input  rise_cnt,
    input  hold_viol
  );

  modport slave (
    input  io_in,
    output io_out,
    output io_oeb,
    output rise_cnt,
    output hold_viol
  );
endinterface

// File: rtl/muller_c_proj_formal_chk.sv
// Clocked harness around a 2-input and a 3-input Muller C-element with an
// independently coded shadow model, sticky divergence flag and rise counter.
module muller_c_proj_formal_chk #(
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  muller_c_proj_formal_chk_if.slave    bus
);

  logic       a, b, ce;
  logic [2:0] c3_in;

  assign a     = bus.io_in[0];
  assign b     = bus.io_in[1];
  assign c3_in = bus.io_in[4:2];
  assign ce    = bus.io_in[5];

  logic             q2_q, q2_d;
  logic             q3_q, q3_d;
  logic             m2_q, m2_d;
  logic             m3_q, m3_d;
  logic             q2_p_q, q2_p_d;
  logic             q3_p_q, q3_p_d;
  logic [5:0]       samp_q, samp_d;
  logic             rise2_q, rise2_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hold2_viol, hold3_viol, shadow_mismatch;

  // Hold property: the previous edge moved q2/q3 although its sampled inputs
  // demanded a hold.
  always_comb begin
    hold2_viol = (q2_q != q2_p_q) &&
                 (!samp_q[5] || (samp_q[0] != samp_q[1]));
    hold3_viol = (q3_q != q3_p_q) &&
                 (!samp_q[5] || ((samp_q[4:2] != 3'b111) && (samp_q[4:2] != 3'b000)));
    shadow_mismatch = ({q2_q, q3_q} != {m2_q, m3_q});
  end

  always_comb begin
    q2_d    = q2_q;
    q3_d    = q3_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    if (ce) begin
      if (a == b) begin
        q2_d = a;
      end
      if (c3_in == 3'b111) begin
        q3_d = 1'b1;
      end else if (c3_in == 3'b000) begin
        q3_d = 1'b0;
      end
      // Shadow: majority form for C2, set/keep form for C3.
      m2_d = (a & b) | (a & m2_q) | (b & m2_q);
      m3_d = (&c3_in) | (m3_q & (|c3_in));
    end

    q2_p_d  = q2_q;
    q3_p_d  = q3_q;
    samp_d  = bus.io_in;
    rise2_d = q2_q & ~q2_p_q;
    err_d   = err_q | shadow_mismatch | hold2_viol | hold3_viol;

    cnt_d = cnt_q;
    if (rise2_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_q    <= 1'b0;
      q3_q    <= 1'b0;
      m2_q    <= 1'b0;
      m3_q    <= 1'b0;
      q2_p_q  <= 1'b0;
      q3_p_q  <= 1'b0;
      samp_q  <= 6'b000000;
      rise2_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      q2_p_q  <= q2_p_d;
      q3_p_q  <= q3_p_d;
      samp_q  <= samp_d;
      rise2_q <= rise2_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.io_out    = {~q2_q, rise2_q, err_q, q2_q & q3_q, q3_q, q2_q};
  assign bus.io_oeb    = 6'b000000;
  assign bus.rise_cnt  = cnt_q;
  assign bus.hold_viol = hold2_viol | hold3_viol;

endmodule

// File: tb/tb_muller_c_proj_formal_chk.sv
// Randomized and directed bench for muller_c_proj_formal_chk against a
// cycle-level behavioural model of the C-element rules.
module tb_muller_c_proj_formal_chk;

  logic clk;
  logic rst_n;

  muller_c_proj_formal_chk_if #(.CNT_W(8)) bus_if ();

  muller_c_proj_formal_chk #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit verbose = 1'b1;

  // Reference state: q2/q3 now, q2 one edge ago, rise pulse, counter.
  int mq2, mq3, mq2_prev, mrise, mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq2 = 0; mq3 = 0; mq2_prev = 0; mrise = 0; mcnt = 0;
  endtask

  task automatic model_edge(input logic [5:0] v);
    int a, b, c, ce, nq2, nq3;
    a  = v[0];
    b  = v[1];
    c  = v[4:2];
    ce = v[5];
    nq2 = mq2;
    nq3 = mq3;
    if (ce == 1 && a == b) nq2 = a;
    if (ce == 1 && c == 7) nq3 = 1;
    if (ce == 1 && c == 0) nq3 = 0;
    // Pulse after the edge that follows a 0->1 transition of q2.
    mrise = (mq2 == 1 && mq2_prev == 0) ? 1 : 0;
    if (mrise == 1 && mcnt < 255) mcnt = mcnt + 1;
    mq2_prev = mq2;
    mq2 = nq2;
    mq3 = nq3;
  endtask

  function automatic logic [5:0] model_out();
    logic [5:0] o;
    o[0] = mq2[0];
    o[1] = mq3[0];
    o[2] = mq2[0] & mq3[0];
    o[3] = 1'b0;
    o[4] = mrise[0];
    o[5] = ~mq2[0];
    return o;
  endfunction

  task automatic step(input logic [5:0] v);
    @(negedge clk);
    bus_if.io_in = v;
    @(posedge clk);
    #1;
    model_edge(v);
    chk("io_out", 32'(bus_if.io_out), 32'(model_out()));
    chk("rise_cnt", 32'(bus_if.rise_cnt), 32'(mcnt));
    chk("hold_viol", 32'(bus_if.hold_viol), 32'd0);
    if (verbose)
      $display("txn io_in=%b io_out=%b rise_cnt=%0d", v, bus_if.io_out, bus_if.rise_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.io_in = 6'b000000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_io_out", 32'(bus_if.io_out), 32'b100000);
    chk("reset_io_oeb", 32'(bus_if.io_oeb), 32'd0);
    chk("reset_cnt", 32'(bus_if.rise_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence from reset.
    step(6'b100011);
    chk("q2_set", 32'(bus_if.io_out), 32'b000001);
    step(6'b100001);
    chk("rise_pulse", 32'(bus_if.io_out), 32'b010001);
    chk("rise_cnt1", 32'(bus_if.rise_cnt), 32'd1);
    step(6'b100000);
    chk("q2_clear", 32'(bus_if.io_out), 32'b100000);
    step(6'b011111);
    chk("ce_hold", 32'(bus_if.io_out[1:0]), 32'b00);
    step(6'b111100);
    chk("q3_set", 32'(bus_if.io_out), 32'b100010);

    // Saturation: one q2 rise per toggle pair.
    verbose = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(6'b100011);
      step(6'b100000);
    end
    chk("cnt_sat", 32'(bus_if.rise_cnt), 32'd255);
    chk("err_after_sat", 32'(bus_if.io_out[3]), 32'd0);

    // Async reset between edges with a rise pulse pending.
    verbose = 1'b1;
    step(6'b100011);
    #2;
    rst_n = 1'b0;
    bus_if.io_in = 6'b000000;
    #1;
    model_reset();
    chk("midrst_io_out", 32'(bus_if.io_out), 32'b100000);
    chk("midrst_cnt", 32'(bus_if.rise_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b000000);
    chk("no_pending_rise", 32'(bus_if.io_out[4]), 32'd0);

    // Random traffic, ce biased high so the elements actually move.
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic [5:0] v;
      v = 6'($urandom);
      if ($urandom_range(0, 3) != 0) v[5] = 1'b1;
      step(v);
    end
    chk("err_final", 32'(bus_if.io_out[3]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
